arena_frame_buffer: RTL and testbench

//   Double-buffered cell store answering the display's arena read port.
//   The Life engine writes the next generation into the back bank while the

---
 rtl/arena_frame_buffer_if.sv | 20 ++
 rtl/arena_frame_buffer.sv | 142 ++++++++++++++
 tb/tb_arena_frame_buffer.sv | 373 +++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/arena_frame_buffer_if.sv
// Engine write channel of the arena frame buffer.
// master: engine (valid/address/data/last); slave: buffer (ready).
interface arena_frame_buffer_if;
    logic       wr_valid;
    logic       wr_ready;
    logic [7:0] wr_row;
    logic [7:0] wr_col;
    logic       wr_value;
    logic       wr_last;

    modport master (
        output wr_valid, wr_row, wr_col, wr_value, wr_last,
        input  wr_ready
    );

    modport slave (
        input  wr_valid, wr_row, wr_col, wr_value, wr_last,
        output wr_ready
    );
endinterface

// File: rtl/arena_frame_buffer.sv
// Double-buffered Life arena: engine fills back bank, display reads front.
// Ports: display/engine read (row/col -> cell), write channel (wr), clear_req,
//   frame_sync, swap_pending, swap_done, gen_count.
module arena_frame_buffer #(
    parameter int ARENA_WIDTH  = 10,
    parameter int ARENA_HEIGHT = 10,
    parameter int GEN_WIDTH    = 16
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic [7:0]           arena_row_select,
    input  logic [7:0]           arena_column_select,
    output logic                 arena_cell_value,
    input  logic                 frame_sync,
    input  logic [7:0]           eng_row,
    input  logic [7:0]           eng_col,
    output logic                 eng_cell,
    arena_frame_buffer_if.slave  wr,
    input  logic                 clear_req,
    output logic                 swap_pending,
    output logic                 swap_done,
    output logic [GEN_WIDTH-1:0] gen_count
);

    typedef logic [ARENA_HEIGHT-1:0][ARENA_WIDTH-1:0] bank_t;
    typedef enum logic [1:0] {S_WRITE, S_SWAP_WAIT, S_CLEAR} state_t;

    state_t               r_state;
    state_t               w_next;
    bank_t                r_bank0;
    bank_t                r_bank1;
    bank_t                w_front;
    logic                 r_front_sel;
    logic [7:0]           r_clr_row;
    logic                 r_swap_done;
    logic [GEN_WIDTH-1:0] r_gen;
    logic                 w_hs;
    logic                 w_swap;
    logic                 w_clr_start;

    // Address match over the real grid only, so out-of-range reads give 0.
    function automatic logic f_read(bank_t b, logic [7:0] row, logic [7:0] col);
        logic v;
        v = 1'b0;
        for (int r = 0; r < ARENA_HEIGHT; r++)
            for (int c = 0; c < ARENA_WIDTH; c++)
                if (row == 8'(r) && col == 8'(c))
                    v = b[r][c];
        return v;
    endfunction

    assign w_front          = r_front_sel ? r_bank1 : r_bank0;
    assign arena_cell_value = f_read(w_front, arena_row_select, arena_column_select);
    assign eng_cell         = f_read(w_front, eng_row, eng_col);
    assign swap_done        = r_swap_done;
    assign gen_count        = r_gen;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) r_state <= S_WRITE;
        else          r_state <= w_next;
    end

    always_comb begin
        w_next       = r_state;
        wr.wr_ready  = 1'b0;
        swap_pending = 1'b0;
        w_hs         = 1'b0;
        w_swap       = 1'b0;
        w_clr_start  = 1'b0;
        unique case (r_state)
            S_WRITE: begin
                wr.wr_ready = 1'b1;
                w_hs        = wr.wr_valid;
                // wr_last wins over clear_req; a plain write still lands first.
                if (w_hs && wr.wr_last) begin
                    w_next = S_SWAP_WAIT;
                end else if (clear_req) begin
                    w_next      = S_CLEAR;
                    w_clr_start = 1'b1;
                end
            end
            S_SWAP_WAIT: begin
                swap_pending = 1'b1;
                if (frame_sync) begin
                    w_swap = 1'b1;
                    w_next = S_WRITE;
                end
            end
            S_CLEAR: begin
                if (r_clr_row == 8'(ARENA_HEIGHT - 1))
                    w_next = S_WRITE;
            end
            default: w_next = S_WRITE;
        endcase
    end

    // Only the back bank (!front_sel) is ever written.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_bank0 <= '0;
            r_bank1 <= '0;
        end else begin
            for (int r = 0; r < ARENA_HEIGHT; r++) begin
                for (int c = 0; c < ARENA_WIDTH; c++) begin
                    if (w_hs && wr.wr_row == 8'(r) && wr.wr_col == 8'(c)) begin
                        if (r_front_sel) r_bank0[r][c] <= wr.wr_value;
                        else             r_bank1[r][c] <= wr.wr_value;
                    end
                    if (r_state == S_CLEAR && r_clr_row == 8'(r)) begin
                        if (r_front_sel) r_bank0[r][c] <= 1'b0;
                        else             r_bank1[r][c] <= 1'b0;
                    end
                end
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_clr_row <= '0;
        end else if (w_clr_start) begin
            r_clr_row <= '0;
        end else if (r_state == S_CLEAR) begin
            r_clr_row <= r_clr_row + 8'd1;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_front_sel <= 1'b0;
            r_gen       <= '0;
            r_swap_done <= 1'b0;
        end else begin
            r_swap_done <= w_swap;
            if (w_swap) begin
                r_front_sel <= ~r_front_sel;
                r_gen       <= r_gen + GEN_WIDTH'(1);
            end
        end
    end

endmodule

// File: tb/tb_arena_frame_buffer.sv
// Self-checking bench for arena_frame_buffer.
// Scoreboard of expected cells against both read ports.
module tb_arena_frame_buffer;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset_n;
    logic [7:0]  disp_row, disp_col, eng_row, eng_col;
    logic        disp_val, eng_val;
    logic        frame_sync, clear_req;
    logic        swap_pending, swap_done;
    logic [15:0] gen_count;

    arena_frame_buffer_if wr_if ();

    arena_frame_buffer dut (
        .clk                 (clk),
        .reset_n             (reset_n),
        .arena_row_select    (disp_row),
        .arena_column_select (disp_col),
        .arena_cell_value    (disp_val),
        .frame_sync          (frame_sync),
        .eng_row             (eng_row),
        .eng_col             (eng_col),
        .eng_cell            (eng_val),
        .wr                  (wr_if),
        .clear_req           (clear_req),
        .swap_pending        (swap_pending),
        .swap_done           (swap_done),
        .gen_count           (gen_count)
    );

    // Narrow generation counter instance for the wrap check.
    logic        w_fs, w_de, w_ee, w_sp, w_sd;
    logic [3:0]  w_gen;
    arena_frame_buffer_if w2_if ();

    arena_frame_buffer #(.GEN_WIDTH(4)) u_wrap (
        .clk                 (clk),
        .reset_n             (reset_n),
        .arena_row_select    (8'd0),
        .arena_column_select (8'd0),
        .arena_cell_value    (w_de),
        .frame_sync          (w_fs),
        .eng_row             (8'd0),
        .eng_col             (8'd0),
        .eng_cell            (w_ee),
        .wr                  (w2_if),
        .clear_req           (1'b0),
        .swap_pending        (w_sp),
        .swap_done           (w_sd),
        .gen_count           (w_gen)
    );

    int n_checks = 0;
    int n_fail   = 0;
    bit q_exp[$];
    bit m_front[10][10];
    bit m_back[10][10];
    int m_gen = 0;

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic model_reset();
        for (int r = 0; r < 10; r++)
            for (int c = 0; c < 10; c++) begin
                m_front[r][c] = 1'b0;
                m_back[r][c]  = 1'b0;
            end
        m_gen = 0;
    endtask

    // Scan the whole grid plus out-of-range addresses on both read ports.
    task automatic read_back(string name);
        bit e;
        for (int r = 0; r < 11; r++) begin
            for (int c = 0; c < 11; c++) begin
                q_exp.push_back((r < 10 && c < 10) ? m_front[r][c] : 1'b0);
                disp_row = 8'(r); disp_col = 8'(c);
                eng_row  = 8'(r); eng_col  = 8'(c);
                #1;
                e = q_exp.pop_front();
                n_checks++;
                if (disp_val !== e) begin
                    n_fail++;
                    $display("FAIL %s disp(%0d,%0d) got %b want %b", name, r, c, disp_val, e);
                end
                n_checks++;
                if (eng_val !== e) begin
                    n_fail++;
                    $display("FAIL %s eng(%0d,%0d) got %b want %b", name, r, c, eng_val, e);
                end
            end
        end
        q_exp.push_back(1'b0);
        disp_row = 8'd0; disp_col = 8'd200; eng_row = 8'd200; eng_col = 8'd0;
        #1;
        e = q_exp.pop_front();
        n_checks++;
        if (disp_val !== e || eng_val !== e) begin
            n_fail++;
            $display("FAIL %s far_oor got %b/%b want %b", name, disp_val, eng_val, e);
        end
    endtask

    task automatic wr_cell(int r, int c, bit v, bit lst, bit clr, bit fs);
        int i;
        i = 0;
        while (!wr_if.wr_ready && i < 50) begin
            cyc();
            i++;
        end
        n_checks++;
        if (!wr_if.wr_ready) begin
            n_fail++;
            $display("FAIL wr_ready_timeout got %b want 1", wr_if.wr_ready);
        end
        wr_if.wr_valid = 1'b1;
        wr_if.wr_row   = 8'(r);
        wr_if.wr_col   = 8'(c);
        wr_if.wr_value = v;
        wr_if.wr_last  = lst;
        clear_req      = clr;
        frame_sync     = fs;
        cyc();
        wr_if.wr_valid = 1'b0;
        wr_if.wr_last  = 1'b0;
        clear_req      = 1'b0;
        frame_sync     = 1'b0;
        if (r < 10 && c < 10) m_back[r][c] = v;
        if (clr && !lst)
            for (int a = 0; a < 10; a++)
                for (int b = 0; b < 10; b++)
                    m_back[a][b] = 1'b0;
    endtask

    task automatic do_swap(string name);
        bit t;
        frame_sync = 1'b1;
        cyc();
        frame_sync = 1'b0;
        m_gen = (m_gen + 1) & 16'hFFFF;
        for (int r = 0; r < 10; r++)
            for (int c = 0; c < 10; c++) begin
                t = m_front[r][c];
                m_front[r][c] = m_back[r][c];
                m_back[r][c]  = t;
            end
        n_checks++;
        if (swap_done !== 1'b1) begin
            n_fail++;
            $display("FAIL %s swap_done got %b want 1", name, swap_done);
        end
        n_checks++;
        if (gen_count !== 16'(m_gen)) begin
            n_fail++;
            $display("FAIL %s gen_count got %0d want %0d", name, gen_count, m_gen);
        end
        n_checks++;
        if (swap_pending !== 1'b0 || wr_if.wr_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL %s post_swap pend/ready got %b/%b want 0/1", name, swap_pending, wr_if.wr_ready);
        end
        cyc();
        n_checks++;
        if (swap_done !== 1'b0) begin
            n_fail++;
            $display("FAIL %s swap_done_pulse got %b want 0", name, swap_done);
        end
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        #17;
        reset_n = 1'b1;
        cyc();
        model_reset();
        n_checks++;
        if (wr_if.wr_ready !== 1'b1 || swap_pending !== 1'b0 ||
            swap_done !== 1'b0 || gen_count !== 16'd0) begin
            n_fail++;
            $display("FAIL reset ready/pend/done/gen got %b/%b/%b/%0d want 1/0/0/0",
                     wr_if.wr_ready, swap_pending, swap_done, gen_count);
        end
        read_back("reset");
    endtask

    task automatic test_tear_free();
        wr_cell(2, 3, 1'b1, 1'b0, 1'b0, 1'b0);
        wr_cell(9, 9, 1'b1, 1'b1, 1'b0, 1'b0);
        // Write/clear attempts must be ignored while waiting.
        wr_if.wr_valid = 1'b1;
        wr_if.wr_row   = 8'd0;
        wr_if.wr_col   = 8'd0;
        wr_if.wr_value = 1'b1;
        clear_req      = 1'b1;
        disp_row = 8'd2; disp_col = 8'd3;
        for (int i = 0; i < 100; i++) begin
            q_exp.push_back(1'b0);
            cyc();
            n_checks++;
            if (disp_val !== q_exp.pop_front()) begin
                n_fail++;
                $display("FAIL tear cyc%0d disp(2,3) got %b want 0", i, disp_val);
            end
            n_checks++;
            if (wr_if.wr_ready !== 1'b0 || swap_pending !== 1'b1) begin
                n_fail++;
                $display("FAIL tear cyc%0d ready/pend got %b/%b want 0/1",
                         i, wr_if.wr_ready, swap_pending);
            end
        end
        wr_if.wr_valid = 1'b0;
        clear_req      = 1'b0;
    endtask

    task automatic test_swap();
        do_swap("swap1");
        read_back("swap1");
    endtask

    task automatic test_out_of_range();
        wr_cell(10, 0, 1'b1, 1'b0, 1'b0, 1'b0);
        wr_cell(0, 200, 1'b1, 1'b1, 1'b0, 1'b0);
        n_checks++;
        if (swap_pending !== 1'b1) begin
            n_fail++;
            $display("FAIL oor pending got %b want 1", swap_pending);
        end
        do_swap("oor");
        read_back("oor");
    endtask

    task automatic test_clear();
        int n;
        wr_cell(4, 4, 1'b1, 1'b0, 1'b0, 1'b0);
        clear_req = 1'b1;
        cyc();
        clear_req = 1'b0;
        for (int a = 0; a < 10; a++)
            for (int b = 0; b < 10; b++)
                m_back[a][b] = 1'b0;
        n = 0;
        while (!wr_if.wr_ready && n < 50) begin
            n++;
            cyc();
        end
        n_checks++;
        if (n != 10) begin
            n_fail++;
            $display("FAIL clear_busy_cycles got %0d want 10", n);
        end
        wr_cell(0, 0, 1'b0, 1'b1, 1'b0, 1'b0);
        do_swap("clear");
        read_back("clear");
    endtask

    task automatic test_simultaneous();
        wr_cell(5, 5, 1'b1, 1'b0, 1'b1, 1'b0);
        wr_cell(1, 1, 1'b1, 1'b1, 1'b0, 1'b1);
        n_checks++;
        if (swap_pending !== 1'b1 || swap_done !== 1'b0 || gen_count !== 16'(m_gen)) begin
            n_fail++;
            $display("FAIL simul_no_swap pend/done/gen got %b/%b/%0d want 1/0/%0d",
                     swap_pending, swap_done, gen_count, m_gen);
        end
        cyc();
        n_checks++;
        if (swap_pending !== 1'b1 || swap_done !== 1'b0) begin
            n_fail++;
            $display("FAIL simul_hold pend/done got %b/%b want 1/0", swap_pending, swap_done);
        end
        do_swap("simul");
        read_back("simul");
    endtask

    task automatic test_reset_mid_clear();
        clear_req = 1'b1;
        cyc();
        clear_req = 1'b0;
        cyc();
        cyc();
        cyc();
        #2;
        reset_n  = 1'b0;
        disp_row = 8'd1; disp_col = 8'd1;
        #1;
        n_checks++;
        if (wr_if.wr_ready !== 1'b1 || gen_count !== 16'd0 || swap_pending !== 1'b0) begin
            n_fail++;
            $display("FAIL rst_mid ready/gen/pend got %b/%0d/%b want 1/0/0",
                     wr_if.wr_ready, gen_count, swap_pending);
        end
        n_checks++;
        if (disp_val !== 1'b0) begin
            n_fail++;
            $display("FAIL rst_mid disp(1,1) got %b want 0", disp_val);
        end
        #1;
        reset_n = 1'b1;
        model_reset();
        cyc();
        n_checks++;
        if (wr_if.wr_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL rst_mid_after ready got %b want 1", wr_if.wr_ready);
        end
        read_back("rst_mid");
    endtask

    task automatic test_gen_wrap();
        int seen;
        seen = 0;
        w2_if.wr_valid = 1'b1;
        w2_if.wr_last  = 1'b1;
        w_fs           = 1'b1;
        for (int i = 0; i < 80 && seen < 16; i++) begin
            cyc();
            if (w_sd) begin
                seen++;
                n_checks++;
                if (w_gen !== 4'(seen)) begin
                    n_fail++;
                    $display("FAIL wrap swap%0d gen got %0d want %0d", seen, w_gen, seen & 15);
                end
            end
        end
        w2_if.wr_valid = 1'b0;
        w2_if.wr_last  = 1'b0;
        w_fs           = 1'b0;
        n_checks++;
        if (seen != 16 || w_gen !== 4'd0) begin
            n_fail++;
            $display("FAIL wrap_final swaps/gen got %0d/%0d want 16/0", seen, w_gen);
        end
    endtask

    initial begin
        reset_n        = 1'b0;
        disp_row       = '0;
        disp_col       = '0;
        eng_row        = '0;
        eng_col        = '0;
        frame_sync     = 1'b0;
        clear_req      = 1'b0;
        wr_if.wr_valid = 1'b0;
        wr_if.wr_row   = '0;
        wr_if.wr_col   = '0;
        wr_if.wr_value = 1'b0;
        wr_if.wr_last  = 1'b0;
        w_fs           = 1'b0;
        w2_if.wr_valid = 1'b0;
        w2_if.wr_row   = '0;
        w2_if.wr_col   = '0;
        w2_if.wr_value = 1'b0;
        w2_if.wr_last  = 1'b0;
        test_reset();
        test_tear_free();
        test_swap();
        test_out_of_range();
        test_clear();
        test_simultaneous();
        test_reset_mid_clear();
        test_gen_wrap();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
